p2s_sched: RTL and testbench
============================

Name: p2s_sched

Overview:
Round-robin scheduler that shares one parallel-to-serial transmitter (16-bit frame, 4-bit length, MSB-first, enable/done handshake, active-high async reset) among N_REQ requesters. Latches the granted frame, drives the serializer for exactly len cycles, checks its done flag and returns an ack or error pulse to the requester. Inserts a programmable idle gap between frames.

Parameters:
N_REQ, 4, number of requesters (2..8)
IFG_CYCLES, 2, idle cycles after each frame before the next grant (min 1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
req  in  N_REQ  per-requester request level; held until ack
req_data  in  16*N_REQ  flat frame bus; slot i = bits [16i+15:16i], payload MSB-aligned
req_len  in  4*N_REQ  flat length bus; slot i = bits [4i+3:4i], bits to send (0..15)
ack  out  N_REQ  one-cycle completion pulse, one-hot
err  out  N_REQ  one-cycle error pulse, coincident with ack
ser_data  out  16  frame to serializer
ser_len  out  4  length to serializer
ser_enable  out  1  serializer enable
ser_rst  out  1  active-high reset to serializer
ser_done  in  1  serializer done flag
busy  out  1  high in every state except IDLE
grant_id  out  $clog2(N_REQ)  index of current/last granted requester

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; ack=0, err=0, ser_enable=0, ser_data=0, ser_len=0, busy=0, grant_id=0, ser_rst=1, rr pointer=N_REQ-1 (requester 0 wins first). ser_rst drops to 0 on the first edge with reset==1. Reset mid-frame aborts: no ack/err issued for the aborted frame.
- All outputs registered.
- FSM IDLE -> LOAD -> SEND -> CHECK -> GAP -> IDLE.
- IDLE: if any req, pick first set bit searching pointer+1, pointer+2, ... wrapping mod N_REQ; latch data/len into ser_data/ser_len, grant_id=pick, pointer=pick.
  - len==0: go directly to GAP, ack[pick]=err[pick]=1 for one cycle (serializer would never finish a zero-length frame; it is never enabled).
  - else -> LOAD.
- LOAD: one cycle, ser_enable=0, ser_data/ser_len stable. Next -> SEND, ser_enable=1, bit counter=0.
- SEND: ser_enable high for exactly ser_len cycles (counter increments each cycle; enable deasserted at the edge where counter reaches ser_len-1). Next -> CHECK.
- CHECK: one cycle, enable low. Serializer done is expected high here.
  - ser_done==1: ack[grant_id]=1 next cycle.
  - ser_done==0: ack[grant_id]=err[grant_id]=1 next cycle; ser_rst=1 for one cycle to re-arm the serializer bit pointer.
  - -> GAP.
- GAP: IFG_CYCLES cycles with enable low (serializer output tri-stated); ack/err high only in the first GAP cycle. -> IDLE.
- Frame latency: grant edge to ack high = len+3 cycles; back-to-back frames start len+3+IFG_CYCLES cycles apart.
- Requester must drop req in response to ack; with IFG_CYCLES>=1 no re-grant of the same request is possible.
- req/data changes after grant are ignored (latched copy used).
- Fairness: with all N_REQ requesting continuously, grants cycle 0,1,..,N_REQ-1,0.

Decomposition:
- Package p2s_pkg: FRAME_W=16, LEN_W=4, state enum (IDLE, LOAD, SEND, CHECK, GAP), gap-counter width helper.
- Sub-module p2s_rr_pick: combinational round-robin picker (req, pointer -> valid, index).

Test Plan:
- Reset: hold reset=0 three cycles with req=4'b1111 -> all outputs at reset values, ser_rst=1, no ack; ser_rst=0 one cycle after release.
- Single frame: req[2]=1, data=16'hA000, len=3 -> ser_enable high exactly 3 cycles, serializer emits 1,0,1; ack[2] high 6 cycles after grant, err=0.
- Round robin: req=4'b1111 continuously, each len=1 -> grant order 0,1,2,3,0; no requester granted twice before others.
- Zero length: req[1]=1, len=0 -> ser_enable never asserts; ack[1]=err[1]=1 one cycle after grant.
- Missing done: model forces ser_done=0, len=5 -> err and ack pulse for the requester, ser_rst pulses one cycle, next frame completes normally.
- Reset mid-SEND: assert reset during cycle 2 of a len=8 frame -> ser_enable=0, ser_rst=1, no ack/err; a new request after release is served from requester 0 priority.

Source files
------------

// File: rtl/p2s_pkg.sv
// p2s_pkg: shared definitions for the parallel-to-serial scheduler.
//   FRAME_W  - width of a frame handed to the serializer
//   LEN_W    - width of the bit-length field
//   state_e  - scheduler FSM states
//   cnt_w()  - width of a down-counter that must hold 0..n-1 (at least 1 bit)
package p2s_pkg;

  localparam int FRAME_W = 16;
  localparam int LEN_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    CHECK,
    GAP
  } state_e;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/p2s_rr_pick.sv
// p2s_rr_pick: combinational round-robin picker.
//   req   - request vector, one bit per requester
//   ptr   - index of the last granted requester
//   valid - at least one request present
//   index - first set request found searching ptr+1, ptr+2, ... modulo N_REQ
module p2s_rr_pick
  import p2s_pkg::*;
#(
  parameter int  N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] cand;

  // Walk the search order backwards so the candidate closest to ptr+1
  // is the last one written and therefore wins.
  always_comb begin
    valid = |req;
    index = ptr;
    cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (req[cand]) begin
        index = cand;
      end
    end
  end

endmodule

// File: rtl/p2s_sched.sv
// p2s_sched: round-robin scheduler sharing one parallel-to-serial transmitter
// among N_REQ requesters.
//   clk, reset           - system clock, synchronous active-low reset
//   req                  - per-requester request level, held until ack
//   req_data / req_len   - flat per-slot frame (16b) and bit length (4b)
//   ack / err            - one-cycle one-hot completion / error pulses
//   ser_data / ser_len   - latched frame and length driven to the serializer
//   ser_enable           - high for exactly ser_len cycles per frame
//   ser_rst              - active-high serializer reset (reset, or missing done)
//   ser_done             - serializer done flag, sampled in CHECK
//   busy                 - high whenever the FSM is not in IDLE
//   grant_id             - index of the current/last granted requester
//
// state | meaning
// IDLE  | wait for a request, pick round-robin, latch frame
// LOAD  | frame stable on ser_data/ser_len, enable still low
// SEND  | ser_enable high, bit down-counter runs to zero
// CHECK | enable low, sample ser_done
// GAP   | inter-frame idle, IFG_CYCLES long; ack/err only in its first cycle
module p2s_sched
  import p2s_pkg::*;
#(
  parameter int  N_REQ      = 4,
  parameter int  IFG_CYCLES = 2,
  localparam int IDX_W      = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [FRAME_W*N_REQ-1:0] req_data,
  input  logic [LEN_W*N_REQ-1:0]   req_len,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         err,
  output logic [FRAME_W-1:0]       ser_data,
  output logic [LEN_W-1:0]         ser_len,
  output logic                     ser_enable,
  output logic                     ser_rst,
  input  logic                     ser_done,
  output logic                     busy,
  output logic [IDX_W-1:0]         grant_id
);

  localparam int               GAP_W    = cnt_w(IFG_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_CYCLES - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_REQ - 1);

  logic [FRAME_W-1:0] slot_data [N_REQ];
  logic [LEN_W-1:0]   slot_len  [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    assign slot_data[g] = req_data[g*FRAME_W +: FRAME_W];
    assign slot_len[g]  = req_len[g*LEN_W +: LEN_W];
  end

  state_e             state_q,    state_d;
  logic [FRAME_W-1:0] ser_data_q, ser_data_d;
  logic [LEN_W-1:0]   ser_len_q,  ser_len_d;
  logic               ser_en_q,   ser_en_d;
  logic               ser_rst_q,  ser_rst_d;
  logic               busy_q,     busy_d;
  logic [IDX_W-1:0]   grant_q,    grant_d;
  logic [IDX_W-1:0]   ptr_q,      ptr_d;
  logic [LEN_W-1:0]   bit_cnt_q,  bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q,  gap_cnt_d;
  logic [N_REQ-1:0]   ack_q,      ack_d;
  logic [N_REQ-1:0]   err_q,      err_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  p2s_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    ser_data_d = ser_data_q;
    ser_len_d  = ser_len_q;
    ser_en_d   = 1'b0;
    ser_rst_d  = 1'b0;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    ack_d      = '0;
    err_d      = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          ser_data_d = slot_data[pick_idx];
          ser_len_d  = slot_len[pick_idx];
          grant_d    = pick_idx;
          ptr_d      = pick_idx;
          // A zero-length frame would never raise done, so it is failed
          // immediately without ever enabling the serializer.
          if (slot_len[pick_idx] == '0) begin
            ack_d[pick_idx] = 1'b1;
            err_d[pick_idx] = 1'b1;
            gap_cnt_d       = GAP_LOAD;
            state_d         = GAP;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        ser_en_d  = 1'b1;
        bit_cnt_d = ser_len_q - LEN_W'(1);
        state_d   = SEND;
      end

      // Enable was raised entering SEND; it stays up while the counter is
      // non-zero and drops on the terminal count, giving ser_len cycles.
      SEND: begin
        if (bit_cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          ser_en_d  = 1'b1;
          bit_cnt_d = bit_cnt_q - LEN_W'(1);
        end
      end

      CHECK: begin
        ack_d[grant_q] = 1'b1;
        err_d[grant_q] = ~ser_done;
        // Missing done leaves the serializer bit pointer mid-frame; re-arm it.
        ser_rst_d      = ~ser_done;
        gap_cnt_d      = GAP_LOAD;
        state_d        = GAP;
      end

      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      ser_data_q <= '0;
      ser_len_q  <= '0;
      ser_en_q   <= 1'b0;
      ser_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      grant_q    <= '0;
      ptr_q      <= PTR_RST;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      ack_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      ser_data_q <= ser_data_d;
      ser_len_q  <= ser_len_d;
      ser_en_q   <= ser_en_d;
      ser_rst_q  <= ser_rst_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign ser_data   = ser_data_q;
  assign ser_len    = ser_len_q;
  assign ser_enable = ser_en_q;
  assign ser_rst    = ser_rst_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_p2s_sched.sv
module tb_p2s_sched;

  localparam int N   = 4;
  localparam int IFG = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [16*N-1:0] req_data;
  logic [4*N-1:0]  req_len;
  logic [N-1:0]    ack, err;
  logic [15:0]     ser_data;
  logic [3:0]      ser_len;
  logic            ser_enable, ser_rst, ser_done, busy;
  logic [1:0]      grant_id;
  logic            force_fail;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  p2s_sched #(.N_REQ(N), .IFG_CYCLES(IFG)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .req_len    (req_len),
    .ack        (ack),
    .err        (err),
    .ser_data   (ser_data),
    .ser_len    (ser_len),
    .ser_enable (ser_enable),
    .ser_rst    (ser_rst),
    .ser_done   (ser_done),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  // Serializer model: MSB-first shift, done after ser_len enabled cycles,
  // async active-high reset. Collected bits land in s_bits.
  logic [15:0] s_sh, s_bits;
  logic        s_done, s_en_prev;
  int          s_cnt;

  always @(posedge clk or posedge ser_rst) begin
    if (ser_rst) begin
      s_done    <= 1'b0;
      s_en_prev <= 1'b0;
      s_cnt     <= 0;
    end else begin
      s_en_prev <= ser_enable;
      if (ser_enable) begin
        if (!s_en_prev) begin
          s_bits <= {15'b0, ser_data[15]};
          s_sh   <= ser_data << 1;
          s_cnt  <= 1;
          s_done <= (int'(ser_len) == 1);
        end else begin
          s_bits <= {s_bits[14:0], s_sh[15]};
          s_sh   <= s_sh << 1;
          s_cnt  <= s_cnt + 1;
          s_done <= (s_cnt + 1 == int'(ser_len));
        end
      end
    end
  end

  assign ser_done = s_done & ~force_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [15:0] d, input logic [3:0] l);
    req_data[i*16 +: 16] = d;
    req_len[i*4 +: 4]    = l;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 60) begin
      @(negedge clk);
      c++;
    end
    check("idle_wait", busy, 0);
  endtask

  typedef struct {
    int          id;
    logic [15:0] data;
    logic [3:0]  len;
    logic        fail;
    logic [15:0] exp_bits;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  // random-phase model state
  int          k, next_decide, ptr, pick, o_g, o_ack_at, o_id, o_len, n_ack, cyc, lat, en_cnt;
  logic        outst, o_fail, o_err;
  logic [15:0] o_data;
  logic [N-1:0] e_ack, e_err;
  logic        e_en, e_rst;

  initial begin
    vecs[0] = '{2, 16'hA000, 4'd3,  1'b0, 16'h0005, 1'b0, 6};
    vecs[1] = '{1, 16'hFFFF, 4'd0,  1'b0, 16'h0000, 1'b1, 1};
    vecs[2] = '{0, 16'h8001, 4'd15, 1'b0, 16'h4000, 1'b0, 18};
    vecs[3] = '{3, 16'h5A5A, 4'd4,  1'b0, 16'h0005, 1'b0, 7};
    vecs[4] = '{3, 16'hC000, 4'd5,  1'b1, 16'h0018, 1'b1, 8};
    vecs[5] = '{2, 16'h1234, 4'd1,  1'b0, 16'h0000, 1'b0, 4};
    vecs[6] = '{0, 16'h8000, 4'd1,  1'b0, 16'h0001, 1'b0, 4};

    // ---------------- reset with all requesting
    reset = 1'b0; force_fail = 1'b0; req = '1; req_data = '0;
    for (int i = 0; i < N; i++) set_slot(i, 16'h0, 4'd1);
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_en", ser_enable, 0);
    check("rst_data", ser_data, 0);
    check("rst_len", ser_len, 0);
    check("rst_busy", busy, 0);
    check("rst_gid", grant_id, 0);
    check("rst_ser_rst", ser_rst, 1);

    // ---------------- release, round robin with everyone requesting
    reset = 1'b1;
    @(negedge clk);
    check("rel_ser_rst", ser_rst, 0);
    check("rel_busy", busy, 1);
    n_ack = 0; cyc = 0;
    while (n_ack < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) if (!req[i]) req[i] = 1'b1;
      if (ack != 0) begin
        for (int i = 0; i < N; i++) if (ack[i]) begin
          check($sformatf("rr_order%0d", n_ack), i, n_ack % N);
          req[i] = 1'b0;
        end
        n_ack++;
      end
    end
    req = '0;
    check("rr_count", n_ack, 5);
    wait_idle();

    // ---------------- table-driven single frames
    for (int v = 0; v < 7; v++) begin
      wait_idle();
      force_fail = vecs[v].fail;
      set_slot(vecs[v].id, vecs[v].data, vecs[v].len);
      req[vecs[v].id] = 1'b1;
      lat = 0; en_cnt = 0;
      do begin
        @(negedge clk);
        lat++;
        if (ser_enable) en_cnt++;
      end while (ack == 0 && lat < 40);
      check($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
      check($sformatf("vec%0d_ack", v), ack, 32'(1) << vecs[v].id);
      check($sformatf("vec%0d_err", v), err, vecs[v].exp_err ? (32'(1) << vecs[v].id) : 0);
      check($sformatf("vec%0d_gid", v), grant_id, vecs[v].id);
      check($sformatf("vec%0d_encnt", v), en_cnt, vecs[v].len);
      check($sformatf("vec%0d_serrst", v), ser_rst, vecs[v].fail && vecs[v].len != 0);
      if (vecs[v].len != 0) check($sformatf("vec%0d_bits", v), s_bits, vecs[v].exp_bits);
      req[vecs[v].id] = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_ack_pulse", v), ack, 0);
      force_fail = 1'b0;
    end

    // ---------------- reset during SEND
    wait_idle();
    set_slot(2, 16'hBEEF, 4'd8);
    req = 4'b0100;
    cyc = 0;
    while (!ser_enable && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ms_en_seen", ser_enable, 1);
    @(negedge clk);
    reset = 1'b0;
    req = 4'b0101;
    set_slot(0, 16'hF000, 4'd2);
    @(negedge clk);
    check("ms_en", ser_enable, 0);
    check("ms_ser_rst", ser_rst, 1);
    check("ms_ack", ack, 0);
    check("ms_err", err, 0);
    check("ms_busy", busy, 0);
    @(negedge clk);
    check("ms_ack2", ack, 0);
    reset = 1'b1;
    for (int f = 0; f < 2; f++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (ack == 0 && cyc < 40);
      check($sformatf("ms_after_ack%0d", f), ack, (f == 0) ? 32'h1 : 32'h4);
      check($sformatf("ms_after_err%0d", f), err, 0);
      req = req & ~ack;
    end
    req = '0;
    wait_idle();

    // ---------------- randomized run against a transaction-level model
    reset = 1'b0; req = '0; force_fail = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    k = 0; next_decide = 0; outst = 1'b0; ptr = N - 1;
    repeat (3000) begin
      if (k > 0) begin
        e_ack = '0; e_err = '0; e_en = 1'b0; e_rst = 1'b0;
        if (outst) begin
          if (k == o_ack_at) begin
            e_ack[o_id] = 1'b1;
            e_err[o_id] = o_err;
            e_rst = o_fail && (o_len != 0);
          end
          if (o_len != 0 && k >= o_g + 2 && k <= o_g + 1 + o_len) e_en = 1'b1;
        end
        check("rnd_ack", ack, e_ack);
        check("rnd_err", err, e_err);
        check("rnd_en", ser_enable, e_en);
        check("rnd_ser_rst", ser_rst, e_rst);
        check("rnd_busy", busy, k < next_decide);
        if (outst && k == o_ack_at) begin
          check("rnd_gid", grant_id, o_id);
          if (o_len != 0) check("rnd_bits", s_bits, o_data >> (16 - o_len));
          outst = 1'b0;
        end
      end
      // requesters
      for (int i = 0; i < N; i++) begin
        if (req[i] && ack[i] && k > 0) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          set_slot(i, 16'($urandom), 4'($urandom_range(0, 15)));
          req[i] = 1'b1;
        end else if (outst && o_id == i && k > o_g && $urandom_range(0, 1) == 0) begin
          set_slot(i, 16'($urandom), 4'($urandom_range(0, 15)));
        end
      end
      // scheduler decision taken at the posedge following this point
      if (k == next_decide) begin
        if (req != 0) begin
          pick = -1;
          for (int o = 1; o <= N; o++) begin
            if (pick < 0 && req[(ptr + o) % N]) pick = (ptr + o) % N;
          end
          ptr    = pick;
          o_id   = pick;
          o_data = req_data[pick*16 +: 16];
          o_len  = int'(req_len[pick*4 +: 4]);
          o_fail = ($urandom_range(0, 5) == 0);
          force_fail = o_fail;
          o_err  = (o_len == 0) || o_fail;
          o_g    = k;
          outst  = 1'b1;
          if (o_len == 0) begin
            o_ack_at    = k + 1;
            next_decide = k + 1 + IFG;
          end else begin
            o_ack_at    = k + o_len + 3;
            next_decide = k + o_len + 3 + IFG;
          end
        end else begin
          next_decide = k + 1;
        end
      end
      @(negedge clk);
      k++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
